// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// load_store_unit : RV64I load/store sequencer for a 64-bit data memory with
//                   1-cycle read latency; sub-dword stores via read-modify-write.
// Revision        : 1.0
// ============================================================================
module load_store_unit #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              fault_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wr_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int NBYTES = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_e;

  state_e            state_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [2:0]        off_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              done_q;
  logic              fault_q;
  logic              mem_wr_q;

  logic              illegal;
  logic              misaligned;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] wd_shift;
  logic [DATA_W-1:0] load_d;
  logic [DATA_W-1:0] merge_d;
  logic [NBYTES-1:0] mask;

  // Request qualification uses the live inputs, since it is decided at accept.
  always_comb begin
    illegal    = we_i ? funct3_i[2] : (funct3_i == 3'b111);
    misaligned = 1'b0;
    case (funct3_i[1:0])
      2'b01:   misaligned = addr_i[0];
      2'b10:   misaligned = |addr_i[1:0];
      2'b11:   misaligned = |addr_i[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    rd_shift = mem_rdata_i >> {off_q, 3'b000};
    wd_shift = wdata_q << {off_q, 3'b000};
    load_d   = rd_shift;
    case (funct3_q)
      3'b000:  load_d = {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_d = {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_d = {{(DATA_W-32){rd_shift[31]}}, rd_shift[31:0]};
      3'b100:  load_d = {{(DATA_W-8){1'b0}}, rd_shift[7:0]};
      3'b101:  load_d = {{(DATA_W-16){1'b0}}, rd_shift[15:0]};
      3'b110:  load_d = {{(DATA_W-32){1'b0}}, rd_shift[31:0]};
      default: load_d = rd_shift;
    endcase
    mask = '0;
    case (funct3_q[1:0])
      2'b00:   mask = 8'h01 << off_q;
      2'b01:   mask = 8'h03 << off_q;
      2'b10:   mask = 8'h0F << off_q;
      default: mask = 8'hFF;
    endcase
    merge_d = mem_rdata_i;
    for (int k = 0; k < NBYTES; k++) begin
      merge_d[8*k +: 8] = mask[k] ? wd_shift[8*k +: 8] : mem_rdata_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 3'b000;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            we_q       <= we_i;
            funct3_q   <= funct3_i;
            off_q      <= addr_i[2:0];
            wdata_q    <= wdata_i;
            mem_addr_q <= {addr_i[ADDR_W-1:3], 3'b000};
            if (illegal || misaligned) begin
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              state_q <= S_RESP;
            end else if (we_i && (funct3_i[1:0] == 2'b11)) begin
              // Full-dword store needs no read phase.
              mem_wdata_q <= wdata_i;
              mem_wr_q    <= 1'b1;
              state_q     <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: state_q <= S_WAIT;
        S_WAIT: begin
          if (we_q) begin
            mem_wdata_q <= merge_d;
            mem_wr_q    <= 1'b1;
            state_q     <= S_WR;
          end else begin
            rdata_q <= load_d;
            done_q  <= 1'b1;
            state_q <= S_RESP;
          end
        end
        S_WR: begin
          done_q  <= 1'b1;
          state_q <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o     = (state_q == S_IDLE) & rst_ni;
  assign done_o      = done_q;
  assign fault_o     = fault_q;
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wr_o    = mem_wr_q;

endmodule
`default_nettype wire
